// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
//   state_e   : control FSM states (ACCUM accepts beats, HOLD presents a result)
//   *_DEF     : default accumulator / counter widths
//   PRODUCT_W : width of the incoming multiplier product
package product_accumulator_pkg;

  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned PRODUCT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add_unsigned.sv
// Unsigned saturating adder: W-bit operand plus an 8-bit operand.
//   a     : W-bit running value
//   b     : 8-bit addend (zero-extended)
//   sum_c : a + b, clamped to all-ones on carry-out
//   sat_c : high when the clamp was applied
module sat_add_unsigned
  import product_accumulator_pkg::*;
#(
  parameter int unsigned W = ACC_W_DEF
) (
  input  logic [W-1:0]         a,
  input  logic [PRODUCT_W-1:0] b,
  output logic [W-1:0]         sum_c,
  output logic                 sat_c
);

  logic [W:0] ext_sum;

  // One extra bit holds the carry that signals saturation.
  always_comb begin
    ext_sum = {1'b0, a} + {{(W + 1 - PRODUCT_W){1'b0}}, b};
    sat_c   = ext_sum[W];
    sum_c   = sat_c ? '1 : ext_sum[W-1:0];
  end

endmodule

// File: rtl/product_accumulator_4.sv
// Frame accumulator for 8-bit multiplier products.
// Sums the beats of a frame into a saturating accumulator and presents one
// result per frame on a valid/ready output.
//   clk, rst_n        : clock, synchronous active-low reset
//   clear             : flush the partial frame
//   in_valid/in_ready : input beat handshake (in_ready is combinational)
//   in_product        : 8-bit unsigned product
//   in_last           : final beat of a frame
//   out_valid/out_ready : result handshake
//   out_sum           : saturated frame sum
//   out_count         : saturating beat count
//   out_overflow      : sum or count saturated within the frame
module product_accumulator_4
  import product_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRODUCT_W-1:0] in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] sum_nxt;
  logic             sum_sat;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_sat;
  logic             ovf_nxt;

  sat_add_unsigned #(.W(ACC_W)) u_sum_add (
    .a     (acc_q),
    .b     (in_product),
    .sum_c (sum_nxt),
    .sat_c (sum_sat)
  );

  sat_add_unsigned #(.W(CNT_W)) u_cnt_add (
    .a     (count_q),
    .b     (PRODUCT_W'(1)),
    .sum_c (cnt_nxt),
    .sat_c (cnt_sat)
  );

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

  // Next-state: clear beats a coinciding beat; the output handshake is
  // independent of clear so a held result can still drain.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    ovf_nxt     = ovf_q | sum_sat | cnt_sat;

    if (clear) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (in_valid && in_ready) begin
      if (in_last) begin
        out_sum_d   = sum_nxt;
        out_count_d = cnt_nxt;
        out_ovf_d   = ovf_nxt;
        acc_d       = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_d   = sum_nxt;
        count_d = cnt_nxt;
        ovf_d   = ovf_nxt;
      end
    end

    if ((state_q == HOLD) && out_ready) begin
      state_d = ACCUM;
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator_4.sv
// Directed bench for product_accumulator_4: default-width instance plus an
// ACC_W=8 instance for sum saturation.
module tb_product_accumulator_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_valid8;
  logic        in_ready;
  logic        in_ready8;
  logic [7:0]  in_product;
  logic        in_last;
  logic        out_valid;
  logic        out_valid8;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_sum8;
  logic [7:0]  out_count;
  logic [7:0]  out_count8;
  logic        out_overflow;
  logic        out_overflow8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator_4 #(.ACC_W(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  product_accumulator_4 #(.ACC_W(8), .CNT_W(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid8),
    .in_ready     (in_ready8),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid8),
    .out_ready    (out_ready),
    .out_sum      (out_sum8),
    .out_count    (out_count8),
    .out_overflow (out_overflow8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one beat for one edge.
  task automatic send(input logic [7:0] p, input logic last, input bit sel8);
    int waited = 0;
    while (((sel8 ? in_ready8 : in_ready) !== 1'b1) && (waited < 20)) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready never rose (waited %0d cycles, required < 20)", waited);
    end
    in_product = p;
    in_last    = last;
    if (sel8) in_valid8 = 1'b1;
    else      in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
    in_product = 8'd0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow: got %b expected 0", out_overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_normal_frame();
    out_ready = 1'b1;
    send(8'd15, 1'b0, 1'b0);
    send(8'd36, 1'b0, 1'b0);
    send(8'd225, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL normal_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_sum !== 16'd276) begin errors++; $display("FAIL normal_out_sum: got %0d expected 276", out_sum); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL normal_out_count: got %0d expected 3", out_count); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL normal_out_overflow: got %b expected 0", out_overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL normal_in_ready_hold: got %b expected 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_valid_drop: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL normal_in_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'd15, 1'b0, 1'b0);
    send(8'd36, 1'b0, 1'b0);
    send(8'd225, 1'b1, 1'b0);
    // Offer a beat the block must ignore while it holds the result.
    in_valid = 1'b1; in_product = 8'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_sum !== 16'd276) begin errors++; $display("FAIL bp_out_sum[%0d]: got %0d expected 276", i, out_sum); end
      checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL bp_out_count[%0d]: got %0d expected 3", i, out_count); end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_sum !== 16'd276) begin errors++; $display("FAIL bp_sum_kept: got %0d expected 276", out_sum); end
    send(8'd4, 1'b1, 1'b0);
    checks++; if (out_sum !== 16'd4) begin errors++; $display("FAIL bp_next_sum: got %0d expected 4", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL bp_next_count: got %0d expected 1", out_count); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    send(8'd200, 1'b0, 1'b1);
    send(8'd100, 1'b1, 1'b1);
    checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", out_valid8); end
    checks++; if (out_sum8 !== 8'd255) begin errors++; $display("FAIL sat_sum: got %0d expected 255", out_sum8); end
    checks++; if (out_overflow8 !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b expected 1", out_overflow8); end
    checks++; if (out_count8 !== 8'd2) begin errors++; $display("FAIL sat_count: got %0d expected 2", out_count8); end
    send(8'd5, 1'b1, 1'b1);
    checks++; if (out_sum8 !== 8'd5) begin errors++; $display("FAIL sat_next_sum: got %0d expected 5", out_sum8); end
    checks++; if (out_overflow8 !== 1'b0) begin errors++; $display("FAIL sat_next_overflow: got %b expected 0", out_overflow8); end
    checks++; if (out_count8 !== 8'd1) begin errors++; $display("FAIL sat_next_count: got %0d expected 1", out_count8); end
  endtask

  task automatic test_count_saturation();
    out_ready = 1'b1;
    // 255 zero beats: count just reaches its maximum without overflowing.
    for (int i = 0; i < 255; i++) send(8'd0, (i == 254), 1'b0);
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL cnt255_count: got %0d expected 255", out_count); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL cnt255_overflow: got %b expected 0", out_overflow); end
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL cnt255_sum: got %0d expected 0", out_sum); end
    // 256 beats: the last increment saturates.
    for (int i = 0; i < 256; i++) send(8'd0, (i == 255), 1'b0);
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL cnt256_count: got %0d expected 255", out_count); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL cnt256_overflow: got %b expected 1", out_overflow); end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send(8'd10, 1'b0, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_product = 8'd30;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    send(8'd7, 1'b1, 1'b0);
    checks++; if (out_sum !== 16'd7) begin errors++; $display("FAIL clear_sum: got %0d expected 7", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clear_count: got %0d expected 1", out_count); end
    tick();
    // Clear together with a last beat: beat dropped, no result.
    clear = 1'b1; in_valid = 1'b1; in_product = 8'd50; in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_last_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_last_in_ready: got %b expected 1", in_ready); end
    send(8'd3, 1'b1, 1'b0);
    checks++; if (out_sum !== 16'd3) begin errors++; $display("FAIL clear_after_sum: got %0d expected 3", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clear_after_count: got %0d expected 1", out_count); end
    // Clear while holding leaves the result untouched.
    out_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_hold_valid: got %b expected 1", out_valid); end
    checks++; if (out_sum !== 16'd3) begin errors++; $display("FAIL clear_hold_sum: got %0d expected 3", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clear_hold_count: got %0d expected 1", out_count); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'd50, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL rstmid_out_sum: got %0d expected 0", out_sum); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    send(8'd9, 1'b1, 1'b0);
    checks++; if (out_sum !== 16'd9) begin errors++; $display("FAIL rstmid_sum: got %0d expected 9", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", out_count); end
    // Reset during HOLD.
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL rsthold_sum: got %0d expected 0", out_sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rsthold_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_saturation();
    test_count_saturation();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
